// File: rtl/apb_arbiter_pkg.sv
// kiscv_apb_pkg: shared types and constants for the two-master APB arbiter
package kiscv_apb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_DONE} apb_arb_state_t;
  typedef logic mst_idx_t;
  localparam int APB_STB_WIDTH = 4;
endpackage

// File: rtl/apb_arbiter_if.sv
// apb_arbiter_if: one APB port; the requester uses master, the responder uses slave
interface apb_arbiter_if
  import kiscv_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pdata;
  logic [APB_STB_WIDTH-1:0] pstb;
  logic psel;
  logic penable;
  logic pwrite;
  logic [DATA_WIDTH-1:0] prdata;
  logic pready;
  logic perr;
  modport master (output paddr, pdata, pstb, psel, penable, pwrite, input prdata, pready, perr);
  modport slave (input paddr, pdata, pstb, psel, penable, pwrite, output prdata, pready, perr);
endinterface

// File: rtl/apb_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; on a tie the master other than last wins
module rr_pick2
  import kiscv_apb_pkg::*;
(
  input  logic [1:0] req_i,
  input  mst_idx_t   last_i,
  output logic       gnt_valid_o,
  output mst_idx_t   gnt_idx_o
);
  assign gnt_valid_o = |req_i;
  assign gnt_idx_o = (&req_i) ? ~last_i : req_i[1];
endmodule

// File: rtl/apb_arbiter.sv
// apb_arbiter: shares one downstream APB slave between two masters, one captured transfer per grant
// Optional ACCESS-phase watchdog enabled by defining APB_ARB_TIMEOUT_EN
module apb_arbiter
  import kiscv_apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rts_n,
  apb_arbiter_if.slave m0,
  apb_arbiter_if.slave m1,
  apb_arbiter_if.master apb
);
  apb_arb_state_t state_q, state_d;
  mst_idx_t gnt_q, gnt_d, last_q, last_d, pick_idx;
  logic pick_valid, timeout, g_psel, g_penable, done0, done1;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d, prdata_q, prdata_d;
  logic [APB_STB_WIDTH-1:0] pstb_q, pstb_d;
  logic pwrite_q, pwrite_d, psel_q, psel_d, penable_q, penable_d, perr_q, perr_d;

  rr_pick2 u_pick (
    .req_i      ({m1.psel, m0.psel}),
    .last_i     (last_q),
    .gnt_valid_o(pick_valid),
    .gnt_idx_o  (pick_idx)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign cnt_d = state_q == ST_ACCESS ? cnt_q + 1'b1 : '0;
  assign timeout = state_q == ST_ACCESS && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign g_psel = gnt_q ? m1.psel : m0.psel;
  assign g_penable = gnt_q ? m1.penable : m0.penable;

  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    last_d = last_q;
    paddr_d = paddr_q;
    pdata_d = pdata_q;
    pstb_d = pstb_q;
    pwrite_d = pwrite_q;
    psel_d = psel_q;
    penable_d = penable_q;
    prdata_d = prdata_q;
    perr_d = perr_q;
    case (state_q)
      ST_IDLE: if (pick_valid) begin
        state_d = ST_SETUP;
        gnt_d = pick_idx;
        paddr_d = pick_idx ? m1.paddr : m0.paddr;
        pdata_d = pick_idx ? m1.pdata : m0.pdata;
        pstb_d = pick_idx ? m1.pstb : m0.pstb;
        pwrite_d = pick_idx ? m1.pwrite : m0.pwrite;
        psel_d = 1'b1;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: if (apb.pready || timeout) begin
        state_d = ST_DONE;
        psel_d = 1'b0;
        penable_d = 1'b0;
        prdata_d = apb.pready ? apb.prdata : '0;
        perr_d = apb.pready ? apb.perr : 1'b1;
      end
      ST_DONE: if (g_penable || !g_psel) begin
        state_d = ST_IDLE;
        last_d = gnt_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      state_q <= ST_IDLE;
      gnt_q <= 1'b0;
      last_q <= 1'b1;
      paddr_q <= '0;
      pdata_q <= '0;
      pstb_q <= '0;
      pwrite_q <= 1'b0;
      psel_q <= 1'b0;
      penable_q <= 1'b0;
      prdata_q <= '0;
      perr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      last_q <= last_d;
      paddr_q <= paddr_d;
      pdata_q <= pdata_d;
      pstb_q <= pstb_d;
      pwrite_q <= pwrite_d;
      psel_q <= psel_d;
      penable_q <= penable_d;
      prdata_q <= prdata_d;
      perr_q <= perr_d;
    end
  end

  assign apb.paddr = paddr_q;
  assign apb.pdata = pdata_q;
  assign apb.pstb = pstb_q;
  assign apb.pwrite = pwrite_q;
  assign apb.psel = psel_q;
  assign apb.penable = penable_q;

  // responses are visible only to the granted master, and only in DONE
  assign done0 = state_q == ST_DONE && gnt_q == 1'b0;
  assign done1 = state_q == ST_DONE && gnt_q == 1'b1;
  assign m0.pready = done0 && m0.penable;
  assign m0.prdata = done0 ? prdata_q : '0;
  assign m0.perr = done0 && perr_q;
  assign m1.pready = done1 && m1.penable;
  assign m1.prdata = done1 ? prdata_q : '0;
  assign m1.perr = done1 && perr_q;
endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: randomized self-checking bench with a slave model and a round-robin/latency reference
module tb_apb_arbiter;
  localparam logic [31:0] KEY = 32'h5EAD_BEEF;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        w;
  } xfer_t;

  logic clk = 1'b0;
  logic rts_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  int slave_wait = 0;
  int acc_cnt = 0;
  logic slave_never = 1'b0;
  logic slave_err = 1'b0;
  logic model_last = 1'b1;
  xfer_t dq[$];
  int r_lat[2];
  logic [31:0] r_rd[2];
  logic r_er[2];
  logic [31:0] g_a[2], g_d[2];
  logic [3:0] g_s[2];
  logic g_w[2];

  apb_arbiter_if u_m0 ();
  apb_arbiter_if u_m1 ();
  apb_arbiter_if u_apb ();

  apb_arbiter dut (
    .clk  (clk),
    .rts_n(rts_n),
    .m0   (u_m0),
    .m1   (u_m1),
    .apb  (u_apb)
  );

  always #5 clk = ~clk;

  // slave: answers after slave_wait ACCESS cycles with data derived from the address
  assign u_apb.pready = u_apb.psel && u_apb.penable && !slave_never && acc_cnt == slave_wait;
  assign u_apb.prdata = u_apb.paddr ^ KEY;
  assign u_apb.perr = slave_err;

  always @(posedge clk) begin
    if (u_apb.psel && u_apb.penable && u_apb.pready)
      dq.push_back('{a: u_apb.paddr, d: u_apb.pdata, s: u_apb.pstb, w: u_apb.pwrite});
    acc_cnt <= (u_apb.psel && u_apb.penable && !u_apb.pready) ? acc_cnt + 1 : 0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish: got running, required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int m, input logic sel, input logic en, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input logic w);
    if (m == 0) begin
      u_m0.psel = sel; u_m0.penable = en; u_m0.paddr = a; u_m0.pdata = d; u_m0.pstb = s; u_m0.pwrite = w;
    end else begin
      u_m1.psel = sel; u_m1.penable = en; u_m1.paddr = a; u_m1.pdata = d; u_m1.pstb = s; u_m1.pwrite = w;
    end
  endtask

  task automatic get_rsp(input int m, output logic rdy, output logic [31:0] rd, output logic er);
    rdy = m == 0 ? u_m0.pready : u_m1.pready;
    rd = m == 0 ? u_m0.prdata : u_m1.prdata;
    er = m == 0 ? u_m0.perr : u_m1.perr;
  endtask

  // one APB transfer from master m; latency counted in cycles from psel assertion to pready
  task automatic mst_xfer(input int m, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic w);
    logic rdy;
    logic [31:0] rd;
    logic er;
    int lat;
    set_req(m, 1'b1, 1'b0, a, d, s, w);
    tick();
    lat = 1;
    set_req(m, 1'b1, 1'b1, a, d, s, w);
    do begin
      tick();
      lat++;
      get_rsp(m, rdy, rd, er);
    end while (!rdy && lat < 2000);
    n_checks++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL m%0d_pready_bound got %b required 1 within 2000 cycles", m, rdy);
    end
    r_lat[m] = lat;
    r_rd[m] = rd;
    r_er[m] = er;
    tick();
    set_req(m, 1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  // sel bit m set means master m requests; both start in the same cycle
  task automatic run_round(input int sel);
    int win, base, exp_lat, first_edge, nexp;
    for (int m = 0; m < 2; m++) begin
      g_a[m] = {4'(m + 1), 12'h0, 14'($urandom), 2'b00};
      g_d[m] = $urandom;
      g_s[m] = 4'($urandom);
      g_w[m] = 1'($urandom);
    end
    slave_wait = $urandom_range(0, 3);
    win = (sel == 3) ? (model_last ? 0 : 1) : (sel == 2 ? 1 : 0);
    base = dq.size();
    fork
      if (sel[0]) mst_xfer(0, g_a[0], g_d[0], g_s[0], g_w[0]);
      if (sel[1]) mst_xfer(1, g_a[1], g_d[1], g_s[1], g_w[1]);
    join
    for (int m = 0; m < 2; m++) begin
      if (sel[m]) begin
        first_edge = (m == win) ? 0 : 4 + slave_wait;
        exp_lat = first_edge + 3 + slave_wait;
        n_checks++;
        if (r_lat[m] !== exp_lat) begin
          n_fail++;
          $display("FAIL rr_latency_m%0d sel=%0d got %0d required %0d", m, sel, r_lat[m], exp_lat);
        end
        n_checks++;
        if (r_rd[m] !== (g_a[m] ^ KEY) || r_er[m] !== 1'b0) begin
          n_fail++;
          $display("FAIL rr_resp_m%0d got %h/%b required %h/0", m, r_rd[m], r_er[m], g_a[m] ^ KEY);
        end
      end
    end
    nexp = (sel == 3) ? 2 : 1;
    n_checks++;
    if (dq.size() !== base + nexp) begin
      n_fail++;
      $display("FAIL rr_downstream_count got %0d required %0d", dq.size() - base, nexp);
    end else begin
      n_checks++;
      if (dq[base].a !== g_a[win] || dq[base].d !== g_d[win] || dq[base].s !== g_s[win] || dq[base].w !== g_w[win]) begin
        n_fail++;
        $display("FAIL rr_first_xfer got a=%h d=%h s=%b w=%b required a=%h d=%h s=%b w=%b",
                 dq[base].a, dq[base].d, dq[base].s, dq[base].w, g_a[win], g_d[win], g_s[win], g_w[win]);
      end
      if (sel == 3) begin
        n_checks++;
        if (dq[base+1].a !== g_a[1-win]) begin
          n_fail++;
          $display("FAIL rr_second_xfer got a=%h required a=%h", dq[base+1].a, g_a[1-win]);
        end
      end
    end
    model_last = (sel == 3) ? 1'(1 - win) : 1'(win);
  endtask

  task automatic test_reset();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    set_req(1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    rts_n = 1'b0;
    #22;
    n_checks++;
    if ({u_apb.psel, u_apb.penable, u_apb.pwrite, u_apb.paddr, u_apb.pdata, u_apb.pstb} !== '0) begin
      n_fail++;
      $display("FAIL reset_downstream got psel=%b pen=%b pw=%b addr=%h data=%h stb=%b required all 0",
               u_apb.psel, u_apb.penable, u_apb.pwrite, u_apb.paddr, u_apb.pdata, u_apb.pstb);
    end
    n_checks++;
    if ({u_m0.pready, u_m0.perr, u_m0.prdata, u_m1.pready, u_m1.perr, u_m1.prdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_masters got m0 %b/%b/%h m1 %b/%b/%h required all 0",
               u_m0.pready, u_m0.perr, u_m0.prdata, u_m1.pready, u_m1.perr, u_m1.prdata);
    end
    @(negedge clk);
    rts_n = 1'b1;
    tick();
    model_last = 1'b1;
  endtask

  task automatic test_contention();
    run_round(3);
    run_round(3);
    for (int r = 0; r < 10; r++) run_round(r < 3 ? 3 : $urandom_range(1, 3));
  endtask

  task automatic test_read_zero_wait();
    slave_wait = 0;
    set_req(0, 1'b1, 1'b0, 32'h8000_0000, '0, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (u_apb.psel !== 1'b1 || u_apb.penable !== 1'b0 || u_apb.paddr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL zw_setup got psel=%b pen=%b addr=%h required 1/0/80000000", u_apb.psel, u_apb.penable, u_apb.paddr);
    end
    set_req(0, 1'b1, 1'b1, 32'h8000_0000, '0, 4'hF, 1'b0);
    tick();
    n_checks++;
    if (u_apb.psel !== 1'b1 || u_apb.penable !== 1'b1) begin
      n_fail++;
      $display("FAIL zw_access got psel=%b pen=%b required 1/1", u_apb.psel, u_apb.penable);
    end
    tick();
    n_checks++;
    if (u_m0.pready !== 1'b1 || u_m0.prdata !== 32'hDEAD_BEEF || u_m0.perr !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_done got pready=%b prdata=%h perr=%b required 1/deadbeef/0", u_m0.pready, u_m0.prdata, u_m0.perr);
    end
    n_checks++;
    if (u_m1.pready !== 1'b0 || u_m1.prdata !== '0 || u_m1.perr !== 1'b0 || u_apb.psel !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_ungranted got m1 %b/%h/%b apb_psel=%b required 0/0/0 psel 0",
               u_m1.pready, u_m1.prdata, u_m1.perr, u_apb.psel);
    end
    tick();
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    model_last = 1'b0;
  endtask

  task automatic test_write_wait();
    int base;
    slave_wait = 3;
    base = dq.size();
    fork
      mst_xfer(1, 32'h10, 32'h1234, 4'b0011, 1'b1);
      begin
        tick();
        tick();
        mst_xfer(0, 32'h40, 32'h0, 4'hF, 1'b0);
      end
    join
    n_checks++;
    if (r_lat[1] !== 6) begin
      n_fail++;
      $display("FAIL ww_m1_latency got %0d required 6", r_lat[1]);
    end
    // m1 frees the bus at edge 7, then m0 needs 3+3 more cycles, counted from its request in cycle 2
    n_checks++;
    if (r_lat[0] !== 11) begin
      n_fail++;
      $display("FAIL ww_m0_latency got %0d required 11", r_lat[0]);
    end
    n_checks++;
    if (dq.size() !== base + 2) begin
      n_fail++;
      $display("FAIL ww_count got %0d required 2", dq.size() - base);
    end else begin
      n_checks++;
      if (dq[base].a !== 32'h10 || dq[base].d !== 32'h1234 || dq[base].s !== 4'b0011 || dq[base].w !== 1'b1) begin
        n_fail++;
        $display("FAIL ww_write got a=%h d=%h s=%b w=%b required 10/1234/0011/1",
                 dq[base].a, dq[base].d, dq[base].s, dq[base].w);
      end
      n_checks++;
      if (dq[base+1].a !== 32'h40 || dq[base+1].s !== 4'hF || dq[base+1].w !== 1'b0) begin
        n_fail++;
        $display("FAIL ww_read got a=%h s=%b w=%b required 40/1111/0", dq[base+1].a, dq[base+1].s, dq[base+1].w);
      end
    end
    n_checks++;
    if (r_rd[0] !== (32'h40 ^ KEY)) begin
      n_fail++;
      $display("FAIL ww_m0_rdata got %h required %h", r_rd[0], 32'h40 ^ KEY);
    end
    model_last = 1'b0;
  endtask

  task automatic test_error();
    slave_wait = $urandom_range(0, 2);
    slave_err = 1'b1;
    mst_xfer(0, 32'h500, 32'h0, 4'hF, 1'b0);
    slave_err = 1'b0;
    n_checks++;
    if (r_er[0] !== 1'b1 || r_lat[0] !== 3 + slave_wait) begin
      n_fail++;
      $display("FAIL err_set got perr=%b lat=%0d required 1/%0d", r_er[0], r_lat[0], 3 + slave_wait);
    end
    mst_xfer(0, 32'h504, 32'h0, 4'hF, 1'b0);
    n_checks++;
    if (r_er[0] !== 1'b0 || r_rd[0] !== (32'h504 ^ KEY)) begin
      n_fail++;
      $display("FAIL err_clear got perr=%b rdata=%h required 0/%h", r_er[0], r_rd[0], 32'h504 ^ KEY);
    end
    model_last = 1'b0;
  endtask

  task automatic test_timeout();
`ifdef APB_ARB_TIMEOUT_EN
    slave_never = 1'b1;
    mst_xfer(0, 32'h300, 32'h0, 4'hF, 1'b0);
    slave_never = 1'b0;
    // SETUP, then 16 ACCESS cycles, then DONE
    n_checks++;
    if (r_lat[0] !== 18 || r_er[0] !== 1'b1 || r_rd[0] !== '0) begin
      n_fail++;
      $display("FAIL timeout_resp got lat=%0d perr=%b rdata=%h required 18/1/0", r_lat[0], r_er[0], r_rd[0]);
    end
    model_last = 1'b0;
`else
    logic seen, stuck;
    slave_never = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h300, '0, 4'hF, 1'b0);
    tick();
    set_req(0, 1'b1, 1'b1, 32'h300, '0, 4'hF, 1'b0);
    seen = 1'b0;
    stuck = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (u_m0.pready) seen = 1'b1;
      if (!(u_apb.psel && u_apb.penable)) stuck = 1'b0;
    end
    n_checks++;
    if (seen !== 1'b0 || stuck !== 1'b1 || u_apb.paddr !== 32'h300) begin
      n_fail++;
      $display("FAIL no_timeout got pready_seen=%b in_access=%b addr=%h required 0/1/300", seen, stuck, u_apb.paddr);
    end
`endif
  endtask

  task automatic test_async_reset();
    slave_never = 1'b1;
    if (!u_apb.penable) begin
      set_req(0, 1'b1, 1'b0, 32'h400, '0, 4'hF, 1'b1);
      tick();
      set_req(0, 1'b1, 1'b1, 32'h400, '0, 4'hF, 1'b1);
      tick();
      tick();
    end
    n_checks++;
    if (u_apb.psel !== 1'b1 || u_apb.penable !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_pre got psel=%b pen=%b required 1/1", u_apb.psel, u_apb.penable);
    end
    #3;
    rts_n = 1'b0;
    #1;
    n_checks++;
    if ({u_apb.psel, u_apb.penable, u_apb.pwrite, u_apb.paddr, u_apb.pstb} !== '0) begin
      n_fail++;
      $display("FAIL arst_downstream got psel=%b pen=%b pw=%b addr=%h stb=%b required all 0",
               u_apb.psel, u_apb.penable, u_apb.pwrite, u_apb.paddr, u_apb.pstb);
    end
    n_checks++;
    if ({u_m0.pready, u_m0.perr, u_m0.prdata} !== '0) begin
      n_fail++;
      $display("FAIL arst_m0 got %b/%b/%h required 0/0/0", u_m0.pready, u_m0.perr, u_m0.prdata);
    end
    set_req(0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    slave_never = 1'b0;
    tick();
    tick();
    rts_n = 1'b1;
    tick();
    model_last = 1'b1;
    run_round(3);
  endtask

  initial begin
    test_reset();
    test_contention();
    test_read_zero_wait();
    test_write_wait();
    test_error();
    test_timeout();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
